// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder: state codes,
// direction encoding and the transition classification helpers.
package quad_pkg;

  // Accepted channel state, packed as {A,B}.
  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  // Direction as seen by the downstream up/down counter.
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Kind of change between two accepted states.
  typedef enum logic [1:0] {
    TR_NONE,
    TR_FWD,
    TR_REV,
    TR_ILL
  } trans_e;

  // Successor of a state in the forward sequence 00->01->11->10->00.
  function automatic logic [1:0] next_fwd(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      Q00:     n = Q01;
      Q01:     n = Q11;
      Q11:     n = Q10;
      default: n = Q00;
    endcase
    return n;
  endfunction

  // Forward if 'to' follows 'from', reverse if 'from' follows 'to',
  // otherwise both channels moved at once and the step is illegal.
  function automatic trans_e classify(input logic [1:0] from, input logic [1:0] to);
    trans_e t;
    if (from == to)                t = TR_NONE;
    else if (to == next_fwd(from)) t = TR_FWD;
    else if (from == next_fwd(to)) t = TR_REV;
    else                           t = TR_ILL;
    return t;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-channel input synchroniser followed by a stability filter. A new
// {A,B} pair is accepted only after FILT_LEN identical synced samples;
// accept_o is high for exactly the cycle in which the change is taken.
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic [1:0] state_o,
  output logic [1:0] next_o,
  output logic       accept_o
);

  localparam int              CNT_W   = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  logic [1:0]             synced;
  logic [1:0]             cand_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             state_q;

  assign synced = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

  // Synchroniser chains run regardless of enable so data is fresh on re-enable.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the synchroniser flops are reset like any other state so the
    // filter never sees X on the first cycles after reset.
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage take the previous
      // stage's old value, which is what makes this a shift chain.
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_i};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_i};
    end
  end

  // Accept once the candidate differs from the held state and has been stable long enough.
  assign accept_o = ena_i && (cand_q != state_q) && (cnt_q == CNT_MAX);

  // Candidate tracking, stability count and accepted state; frozen while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q  <= Q00;
      cnt_q   <= '0;
      state_q <= Q00;
    end else if (ena_i) begin
      if (synced != cand_q) begin
        cand_q <= synced;
        cnt_q  <= CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (accept_o) begin
        state_q <= cand_q;
      end
    end
  end

  assign state_o = state_q;
  assign next_o  = cand_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder top: turns filtered A/B changes into step/dir pulses
// for an up/down counter, flags two-bit jumps and counts them.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr_err,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       phase
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  logic [1:0]       cur_state;
  logic [1:0]       new_state;
  logic             accept;
  trans_e           trans;

  logic             primed_q, primed_d;
  logic             step_q,   step_d;
  logic             dir_q,    dir_d;
  logic             err_q,    err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  quad_input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .ena_i    (ena),
    .a_i      (a_in),
    .b_i      (b_in),
    .state_o  (cur_state),
    .next_o   (new_state),
    .accept_o (accept)
  );

  // Decode the accepted transition into next-cycle step/dir/err and counter values.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    trans     = classify(cur_state, new_state);
    step_d    = 1'b0;
    err_d     = 1'b0;
    dir_d     = dir_q;
    primed_d  = ena ? (primed_q | accept) : 1'b0;
    err_cnt_d = err_cnt_q;

    // The first accepted state after reset or re-enable only primes the decoder.
    if (accept && primed_q) begin
      if (trans == TR_FWD || trans == TR_REV) begin
        step_d = 1'b1;
        dir_d  = (trans == TR_REV) ? DIR_DN : DIR_UP;
      end else if (trans == TR_ILL) begin
        err_d = 1'b1;
      end
    end

    // A clear coinciding with an error pulse keeps that pulse counted.
    if (clr_err) begin
      err_cnt_d = err_q ? ERR_ONE : '0;
    end else if (err_q && err_cnt_q != ERR_MAX) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end
  end

  // Registered outputs and priming flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q  <= 1'b0;
      step_q    <= 1'b0;
      dir_q     <= DIR_UP;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      primed_q  <= primed_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign step    = step_q;
  assign dir     = dir_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign phase   = cur_state;

endmodule
